sdram_arbiter: RTL and testbench

- Two-requester arbiter in front of the user port of the SDRAM controller: m0 (instruction fetch) and m1 (data/DMA).
- Serialises requests, drives one command at a time into the controller's in_valid/busy handshake, and routes read data back to the owning requester only.
- Sits between the user-side bus adapters and the controller, on the same clock and reset.
- Only one transaction is outstanding at any time. There is no pipelining across requesters.

---
 rtl/sdram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of the SDRAM controller user port.
// One transaction outstanding at a time; every output is driven from a flop.
module sdram_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] sdr_addr,
    output logic              sdr_rw,
    output logic [DATA_W-1:0] sdr_wdata,
    output logic              sdr_in_valid,
    input  logic              sdr_busy,
    input  logic [DATA_W-1:0] sdr_rdata,
    input  logic              sdr_out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              rr_last_q, rr_last_d;       // index of the last granted requester
    logic              owner_q, owner_d;           // requester owning the current transaction
    logic              is_read_q, is_read_d;
    logic              first_wait_q, first_wait_d; // busy is not yet meaningful in this cycle
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              in_valid_q, in_valid_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic win_m1;

    // Winner selection: single requester wins outright; on contention either
    // m0 always wins or the requester that was not granted last wins.
    always_comb begin
        win_m1 = m1_req;
        if (m0_req && m1_req) begin
            if (FIXED_PRIO != 0) begin
                win_m1 = 1'b0;
            end else begin
                win_m1 = ~rr_last_q;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT sequence.
    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        owner_d      = owner_q;
        is_read_d    = is_read_q;
        first_wait_d = first_wait_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        in_valid_d   = in_valid_q;
        ack_d        = 2'b00;
        rvalid_d     = 2'b00;

        case (state_q)
            IDLE: begin
                if (!sdr_busy && (m0_req || m1_req)) begin
                    owner_d    = win_m1;
                    rr_last_d  = win_m1;
                    addr_d     = win_m1 ? m1_addr  : m0_addr;
                    rw_d       = win_m1 ? m1_rw    : m0_rw;
                    wdata_d    = win_m1 ? m1_wdata : m0_wdata;
                    in_valid_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Command is held unchanged until the controller is not busy.
                if (!sdr_busy) begin
                    in_valid_d       = 1'b0;
                    ack_d[owner_q]   = 1'b1;
                    is_read_d        = ~rw_q;
                    first_wait_d     = 1'b1;
                    state_d          = WAIT;
                end
            end
            WAIT: begin
                first_wait_d = 1'b0;
                if (is_read_q) begin
                    if (sdr_out_valid) begin
                        rvalid_d[owner_q] = 1'b1;
                        state_d           = IDLE;
                    end
                end else if (!first_wait_q && !sdr_busy) begin
                    // Controller raises busy one cycle late, so the first
                    // WAIT cycle cannot signal write completion.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-requester read data holds its last value until its own rvalid.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
        assign rdata_d[gi] = rvalid_d[gi] ? sdr_rdata : rdata_q[gi];
    end

    // State and output registers; rr_last resets to 1 so m0 wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_last_q    <= 1'b1;
            owner_q      <= 1'b0;
            is_read_q    <= 1'b0;
            first_wait_q <= 1'b0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            in_valid_q   <= 1'b0;
            ack_q        <= 2'b00;
            rvalid_q     <= 2'b00;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            owner_q      <= owner_d;
            is_read_q    <= is_read_d;
            first_wait_q <= first_wait_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            in_valid_q   <= in_valid_d;
            ack_q        <= ack_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign m0_ack       = ack_q[0];
    assign m1_ack       = ack_q[1];
    assign m0_rvalid    = rvalid_q[0];
    assign m1_rvalid    = rvalid_q[1];
    assign m0_rdata     = rdata_q[0];
    assign m1_rdata     = rdata_q[1];
    assign sdr_addr     = addr_q;
    assign sdr_rw       = rw_q;
    assign sdr_wdata    = wdata_q;
    assign sdr_in_valid = in_valid_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// Each instance has its own controller model; a scoreboard checks acks and read data.
module tb_sdram_arbiter;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    typedef struct {
        logic              owner;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;

    logic [1:0] m0_req, m0_rw, m1_req, m1_rw, force_busy;
    logic [1:0][ADDR_W-1:0] m0_addr, m1_addr;
    logic [1:0][DATA_W-1:0] m0_wdata, m1_wdata;

    wire [1:0] m0_ack, m0_rvalid, m1_ack, m1_rvalid;
    wire [1:0] sdr_rw, sdr_in_valid, sdr_busy, sdr_out_valid;
    wire [1:0][DATA_W-1:0] m0_rdata, m1_rdata, sdr_wdata, sdr_rdata;
    wire [1:0][ADDR_W-1:0] sdr_addr;

    int n_cmp = 0;
    int n_mis = 0;
    int rd_cnt [2];

    txn_t acc0[$];
    txn_t acc1[$];
    txn_t rdq0[$];
    txn_t rdq1[$];

    always #5 clk = ~clk;

    // Controller model: accept when not busy, raise busy a cycle later for
    // 6 cycles, return read data (0x1234 + read index) as busy falls.
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [1:0]        ph_q;
        logic [2:0]        cnt_q;
        logic              busy_q, ov_q, rd_q;
        logic [DATA_W-1:0] rdat_q, nrd_q;

        assign sdr_busy[gi]      = busy_q | force_busy[gi];
        assign sdr_out_valid[gi] = ov_q;
        assign sdr_rdata[gi]     = rdat_q;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                ph_q   <= 2'd0;
                cnt_q  <= 3'd0;
                busy_q <= 1'b0;
                ov_q   <= 1'b0;
                rd_q   <= 1'b0;
                rdat_q <= '0;
                nrd_q  <= '0;
            end else begin
                ov_q <= 1'b0;
                case (ph_q)
                    2'd0: begin
                        if (sdr_in_valid[gi] && !sdr_busy[gi]) begin
                            ph_q <= 2'd1;
                            rd_q <= ~sdr_rw[gi];
                        end
                    end
                    2'd1: begin
                        ph_q   <= 2'd2;
                        busy_q <= 1'b1;
                        cnt_q  <= 3'd6;
                    end
                    default: begin
                        if (cnt_q == 3'd1) begin
                            busy_q <= 1'b0;
                            ph_q   <= 2'd0;
                            if (rd_q) begin
                                ov_q   <= 1'b1;
                                rdat_q <= 32'h0000_1234 + nrd_q;
                                nrd_q  <= nrd_q + 1;
                            end
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                endcase
            end
        end

        sdram_arbiter #(
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W),
            .FIXED_PRIO(gi)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .m0_req       (m0_req[gi]),
            .m0_rw        (m0_rw[gi]),
            .m0_addr      (m0_addr[gi]),
            .m0_wdata     (m0_wdata[gi]),
            .m0_ack       (m0_ack[gi]),
            .m0_rvalid    (m0_rvalid[gi]),
            .m0_rdata     (m0_rdata[gi]),
            .m1_req       (m1_req[gi]),
            .m1_rw        (m1_rw[gi]),
            .m1_addr      (m1_addr[gi]),
            .m1_wdata     (m1_wdata[gi]),
            .m1_ack       (m1_ack[gi]),
            .m1_rvalid    (m1_rvalid[gi]),
            .m1_rdata     (m1_rdata[gi]),
            .sdr_addr     (sdr_addr[gi]),
            .sdr_rw       (sdr_rw[gi]),
            .sdr_wdata    (sdr_wdata[gi]),
            .sdr_in_valid (sdr_in_valid[gi]),
            .sdr_busy     (sdr_busy[gi]),
            .sdr_rdata    (sdr_rdata[gi]),
            .sdr_out_valid(sdr_out_valid[gi])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input int i);
        return (i == 0) ? acc0.size() : acc1.size();
    endfunction

    function automatic int rd_size(input int i);
        return (i == 0) ? rdq0.size() : rdq1.size();
    endfunction

    function automatic void acc_push(input int i, input txn_t t);
        if (i == 0) acc0.push_back(t); else acc1.push_back(t);
    endfunction

    function automatic void rd_push(input int i, input txn_t t);
        if (i == 0) rdq0.push_back(t); else rdq1.push_back(t);
    endfunction

    function automatic txn_t acc_pop(input int i);
        if (i == 0) return acc0.pop_front();
        return acc1.pop_front();
    endfunction

    function automatic txn_t rd_pop(input int i);
        if (i == 0) return rdq0.pop_front();
        return rdq1.pop_front();
    endfunction

    // Push the expected result of a transaction in the order it should be granted.
    task automatic expect_txn(input int i, input logic owner, input logic rw,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        txn_t t;
        t.owner = owner;
        t.rw    = rw;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = rw ? '0 : DATA_W'(32'h0000_1234 + rd_cnt[i]);
        if (!rw) rd_cnt[i]++;
        acc_push(i, t);
    endtask

    // Compare ack / rvalid pulses of one instance against the scoreboard.
    task automatic mon(input int i);
        txn_t t;
        logic a0, a1, v0, v1;
        logic [DATA_W-1:0] rd;
        a0 = m0_ack[i];
        a1 = m1_ack[i];
        v0 = m0_rvalid[i];
        v1 = m1_rvalid[i];
        if (a0 || a1) begin
            chk($sformatf("i%0d_ack_onehot", i), a0 & a1, 0);
            chk($sformatf("i%0d_ack_expected", i), acc_size(i) > 0, 1);
            if (acc_size(i) > 0) begin
                t = acc_pop(i);
                chk($sformatf("i%0d_ack_owner", i), a1, t.owner);
                chk($sformatf("i%0d_sdr_addr", i), sdr_addr[i], t.addr);
                chk($sformatf("i%0d_sdr_rw", i), sdr_rw[i], t.rw);
                if (t.rw) chk($sformatf("i%0d_sdr_wdata", i), sdr_wdata[i], t.wdata);
                else rd_push(i, t);
                $display("i%0d ack   owner=m%0d rw=%0d addr=%06h", i, a1, sdr_rw[i], sdr_addr[i]);
            end
        end
        if (v0 || v1) begin
            chk($sformatf("i%0d_rvalid_onehot", i), v0 & v1, 0);
            chk($sformatf("i%0d_rvalid_expected", i), rd_size(i) > 0, 1);
            if (rd_size(i) > 0) begin
                t = rd_pop(i);
                rd = v1 ? m1_rdata[i] : m0_rdata[i];
                chk($sformatf("i%0d_rvalid_owner", i), v1, t.owner);
                chk($sformatf("i%0d_rdata", i), rd, t.rdata);
                $display("i%0d read  owner=m%0d rdata=%08h", i, v1, rd);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    // Hold requests until each master has seen its number of acks, then drop them.
    task automatic run_acks(input int i, input int n0, input int n1);
        int c0, c1, k;
        c0 = 0; c1 = 0; k = 0;
        while ((c0 < n0 || c1 < n1) && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (m0_ack[i]) begin c0++; if (c0 >= n0) m0_req[i] = 1'b0; end
            if (m1_ack[i]) begin c1++; if (c1 >= n1) m1_req[i] = 1'b0; end
        end
        chk($sformatf("i%0d_ack_count", i), {32'(c0), 32'(c1)}, {32'(n0), 32'(n1)});
        m0_req[i] = 1'b0;
        m1_req[i] = 1'b0;
    endtask

    task automatic wait_drain(input int i);
        int k;
        k = 0;
        while ((acc_size(i) != 0 || rd_size(i) != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("i%0d_drain", i), acc_size(i) + rd_size(i), 0);
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk(tag, {m0_ack[i], m0_rvalid[i], m1_ack[i], m1_rvalid[i],
                  sdr_rw[i], sdr_in_valid[i], sdr_addr[i]}, 0);
        chk({tag, "_rdata"}, {m0_rdata[i], m1_rdata[i]}, 0);
        chk({tag, "_wdata"}, sdr_wdata[i], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        m0_req     = '0; m0_rw = '0; m0_addr = '0; m0_wdata = '0;
        m1_req     = '0; m1_rw = '0; m1_addr = '0; m1_wdata = '0;
        force_busy = '0;
        rd_cnt[0]  = 0;
        rd_cnt[1]  = 0;

        // Reset state of both instances
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "rst_i0");
        chk_zero(1, "rst_i1");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_zero(0, "post_rst_i0");

        // m0 read: in_valid at T+1, ack at T+2, data 0x1234 back to m0
        m0_rw[0]   = 1'b0;
        m0_addr[0] = 23'h000100;
        expect_txn(0, 1'b0, 1'b0, 23'h000100, '0);
        m0_req[0]  = 1'b1;
        @(posedge clk); #1;
        chk("s1_in_valid_T1", sdr_in_valid[0], 1);
        chk("s1_ack_T1", m0_ack[0], 0);
        @(posedge clk); #1;
        chk("s1_ack_T2", m0_ack[0], 1);
        chk("s1_in_valid_T2", sdr_in_valid[0], 0);
        m0_req[0] = 1'b0;
        wait_drain(0);
        chk("s1_m0_rdata_hold", m0_rdata[0], 32'h0000_1234);

        // m1 write
        m1_rw[0]    = 1'b1;
        m1_addr[0]  = 23'h000200;
        m1_wdata[0] = 32'hA5A5_5A5A;
        expect_txn(0, 1'b1, 1'b1, 23'h000200, 32'hA5A5_5A5A);
        m1_req[0]   = 1'b1;
        run_acks(0, 0, 1);
        wait_drain(0);

        // Round-robin contention, 4 reads: m0, m1, m0, m1
        m0_rw[0] = 1'b0; m0_addr[0] = 23'h000300;
        m1_rw[0] = 1'b0; m1_addr[0] = 23'h000400;
        expect_txn(0, 1'b0, 1'b0, 23'h000300, '0);
        expect_txn(0, 1'b1, 1'b0, 23'h000400, '0);
        expect_txn(0, 1'b0, 1'b0, 23'h000300, '0);
        expect_txn(0, 1'b1, 1'b0, 23'h000400, '0);
        m0_req[0] = 1'b1;
        m1_req[0] = 1'b1;
        run_acks(0, 2, 2);
        wait_drain(0);

        // Fixed priority: m0 wins 4 times, m1 only after m0 drops
        m0_rw[1] = 1'b0; m0_addr[1] = 23'h000500;
        m1_rw[1] = 1'b0; m1_addr[1] = 23'h000600;
        for (int n = 0; n < 4; n++) expect_txn(1, 1'b0, 1'b0, 23'h000500, '0);
        expect_txn(1, 1'b1, 1'b0, 23'h000600, '0);
        m0_req[1] = 1'b1;
        m1_req[1] = 1'b1;
        run_acks(1, 4, 1);
        wait_drain(1);

        // Controller busy for 5 cycles during ISSUE: command held stable
        m0_rw[0]   = 1'b0;
        m0_addr[0] = 23'h000700;
        expect_txn(0, 1'b0, 1'b0, 23'h000700, '0);
        m0_req[0]  = 1'b1;
        @(posedge clk); #1;
        chk("s5_in_valid_grant", sdr_in_valid[0], 1);
        force_busy[0] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            chk($sformatf("s5_in_valid_stall%0d", n), sdr_in_valid[0], 1);
            chk($sformatf("s5_addr_stall%0d", n), sdr_addr[0], 23'h000700);
            chk($sformatf("s5_ack_stall%0d", n), {m0_ack[0], m1_ack[0]}, 0);
        end
        force_busy[0] = 1'b0;
        @(posedge clk); #1;
        chk("s5_ack_after_busy", {m0_ack[0], m1_ack[0]}, 2'b10);
        m0_req[0] = 1'b0;
        @(posedge clk); #1;
        chk("s5_ack_single", {m0_ack[0], m1_ack[0]}, 0);
        wait_drain(0);

        // Reset during WAIT-read, then m1 is granted first
        m0_rw[0]   = 1'b0;
        m0_addr[0] = 23'h000800;
        expect_txn(0, 1'b0, 1'b0, 23'h000800, '0);
        m0_req[0]  = 1'b1;
        run_acks(0, 1, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero(0, "s6_mid_rst");
        acc0.delete(); acc1.delete(); rdq0.delete(); rdq1.delete();
        rd_cnt[0] = 0;
        rd_cnt[1] = 0;
        m1_rw[0]   = 1'b0;
        m1_addr[0] = 23'h000900;
        expect_txn(0, 1'b1, 1'b0, 23'h000900, '0);
        m1_req[0]  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_acks(0, 0, 1);
        wait_drain(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
